// File: rtl/set_job_dispatcher.sv
// Job FIFO and single-in-flight issuer for the SET circle-set engine, returning results with tags.
// Optional watchdog in WAIT enabled by defining SET_DISPATCH_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a queued job, SET not busy and no result outstanding
// ISSUE | job popped into set_* regs; set_en strobes on leaving this state
// WAIT  | job in flight, waiting for set_valid (or watchdog expiry)
// HOLD  | result presented on res_*, waiting for consumer handshake
module set_job_dispatcher #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [23:0]                   in_central,
  input  logic [11:0]                   in_radius,
  input  logic [1:0]                    in_mode,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          set_en,
  output logic [23:0]                   set_central,
  output logic [11:0]                   set_radius,
  output logic [1:0]                    set_mode,
  input  logic                          set_busy,
  input  logic                          set_valid,
  input  logic [7:0]                    set_candidate,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [7:0]                    res_candidate,
  output logic [TAG_W-1:0]              res_tag,
  output logic [1:0]                    res_mode,
  output logic                          res_err,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic [15:0]                   jobs_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int JW = 24 + 12 + 2 + TAG_W;
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, HOLD = 2'd3} state_t;
  state_t state, state_next;

  logic [JW-1:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count_next;
  logic [JW-1:0]    head;
  logic [TAG_W-1:0] job_tag;
  logic             push, pop, capture, timeout, done, wd_tc;

  assign push = in_valid & in_ready;
  assign head = fifo_mem[rd_ptr];

  always_comb begin
    count_next = pending;
    if (push && !pop)      count_next = pending + 1'b1;
    else if (pop && !push) count_next = pending - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {in_central, in_radius, in_mode, in_tag};
  end

  // in_ready is registered from the next occupancy so it never depends on a same-cycle pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pending  <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      pending  <= count_next;
      in_ready <= (count_next != FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (pending != '0 && !set_busy && !res_valid) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (set_valid) begin
          capture    = 1'b1;
          state_next = HOLD;
        end else if (wd_tc) begin
          timeout    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef SET_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] wd_cnt;

  // Loaded while in ISSUE so it reaches zero on the TIMEOUT_CYCLES-th WAIT cycle
  always_ff @(posedge clk) begin
    if (rst)                               wd_cnt <= '0;
    else if (state == ISSUE)               wd_cnt <= TW'(TIMEOUT_CYCLES - 1);
    else if (state == WAIT && wd_cnt != '0) wd_cnt <= wd_cnt - 1'b1;
  end
  assign wd_tc = (state == WAIT) && (wd_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst)          res_err <= 1'b0;
    else if (timeout) res_err <= 1'b1;
    else if (done)    res_err <= 1'b0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign wd_tc   = 1'b0;
  assign res_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      set_en        <= 1'b0;
      set_central   <= '0;
      set_radius    <= '0;
      set_mode      <= '0;
      job_tag       <= '0;
      res_valid     <= 1'b0;
      res_candidate <= '0;
      res_tag       <= '0;
      res_mode      <= '0;
      jobs_done     <= '0;
    end else begin
      set_en <= (state == ISSUE);
      if (pop) {set_central, set_radius, set_mode, job_tag} <= head;
      if (capture || timeout) begin
        res_valid     <= 1'b1;
        res_candidate <= capture ? set_candidate : 8'hFF;
        res_tag       <= job_tag;
        res_mode      <= set_mode;
      end else if (done) begin
        res_valid <= 1'b0;
      end
      if (done) jobs_done <= jobs_done + 16'd1;
    end
  end
endmodule
